// File: rtl/ipsmacge_rxframer.sv
// GE MAC receive framer: preamble/SFD hunt, FCS strip, on-the-fly CRC-32 check, end-of-frame status.
// Pause-frame detection is built only when IPSMACGE_RXPAUSE_EN is defined.
module ipsmacge_rxframer #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int LEN_DW  = 14
) (
    input  logic              rxclk,
    input  logic              rxrst_,
    input  logic              up_en,
    input  logic              gmii_rxdv,
    input  logic              gmii_rxer,
    input  logic [7:0]        gmii_rxd,
    output logic              rx_vld,
    output logic [7:0]        rx_dat,
    output logic              rx_sop,
    output logic              rx_eop,
    output logic [LEN_DW-1:0] sta_len,
    output logic              sta_fcser,
    output logic              sta_runt,
    output logic              sta_long,
    output logic              sta_gmiier,
    output logic              sta_abort,
    output logic              rx_drop,
    output logic              pau_vld,
    output logic [15:0]       pau_quanta,
    output logic [1:0]        stt_rx
);
    typedef enum logic [1:0] {IDLE = 2'd0, PRM = 2'd1, PAY = 2'd2, DROP = 2'd3} state_t;

    localparam logic [31:0]       CRC_RES = 32'hC704DD7B;
    localparam logic [LEN_DW-1:0] LEN_SAT = '1;
    localparam logic [LEN_DW-1:0] MIN_L   = LEN_DW'(MIN_LEN);
    localparam logic [LEN_DW-1:0] MAX_L   = LEN_DW'(MAX_LEN);
    localparam logic [LEN_DW-1:0] L5      = LEN_DW'(5);
    localparam logic [LEN_DW-1:0] L6      = LEN_DW'(6);

    // MSB-first CRC-32 register fed with each byte LSB first (wire order)
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic [7:0]  b;
        r = c;
        b = d;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[31] ^ b[0]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
            b = b >> 1;
        end
        return r;
    endfunction

    state_t            state, state_nxt;
    logic [LEN_DW-1:0] len;
    logic [31:0]       crc;
    logic              gmiier;
    logic [4:0][7:0]   dly;
    logic              sof, byte_in, close, cut;
    logic              len_ge5, len_ge6, fcs_bad, is_runt, is_long;

    assign sof     = up_en && (state == PRM) && gmii_rxdv && (gmii_rxd == 8'hD5);
    assign byte_in = up_en && (state == PAY) && gmii_rxdv;
    assign close   = up_en && (state == PAY) && !gmii_rxdv;
    assign cut     = !up_en && (state == PAY);
    assign len_ge5 = len >= L5;
    assign len_ge6 = len >= L6;
    assign fcs_bad = crc != CRC_RES;
    assign is_runt = len < MIN_L;
    assign is_long = len > MAX_L;
    assign stt_rx  = state;

    always_ff @(posedge rxclk or negedge rxrst_) begin
        if (!rxrst_) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!up_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (gmii_rxdv) state_nxt = (gmii_rxd == 8'h55) ? PRM : DROP;
                PRM: begin
                    if (!gmii_rxdv)               state_nxt = IDLE;
                    else if (gmii_rxd == 8'h55)   state_nxt = PRM;
                    else if (gmii_rxd == 8'hD5)   state_nxt = PAY;
                    else                          state_nxt = DROP;
                end
                PAY:  if (!gmii_rxdv) state_nxt = IDLE;
                DROP: if (!gmii_rxdv) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge rxclk or negedge rxrst_) begin
        if (!rxrst_) begin
            len        <= '0;
            crc        <= '0;
            gmiier     <= 1'b0;
            dly        <= '0;
            rx_vld     <= 1'b0;
            rx_dat     <= '0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            sta_len    <= '0;
            sta_fcser  <= 1'b0;
            sta_runt   <= 1'b0;
            sta_long   <= 1'b0;
            sta_gmiier <= 1'b0;
            sta_abort  <= 1'b0;
            rx_drop    <= 1'b0;
        end else begin
            rx_vld     <= 1'b0;
            rx_dat     <= '0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            sta_len    <= '0;
            sta_fcser  <= 1'b0;
            sta_runt   <= 1'b0;
            sta_long   <= 1'b0;
            sta_gmiier <= 1'b0;
            sta_abort  <= 1'b0;
            rx_drop    <= 1'b0;
            if (sof) begin
                len    <= '0;
                crc    <= '1;
                gmiier <= 1'b0;
                dly    <= '0;
            end
            if (byte_in) begin
                len <= (len == LEN_SAT) ? len : len + 1'b1;
                crc <= crc_byte(crc, gmii_rxd);
                dly <= {dly[3:0], gmii_rxd};
                if (gmii_rxer) gmiier <= 1'b1;
                // dly[4] is byte len-4 after the shift, so the tail 4 bytes (FCS) never leave
                if (len_ge5) begin
                    rx_vld <= 1'b1;
                    rx_dat <= dly[4];
                    rx_sop <= (len == L5);
                end
            end
            // An abort only closes with eop once sop has already gone out
            if (close || cut) begin
                if (close ? len_ge5 : len_ge6) begin
                    rx_vld     <= 1'b1;
                    rx_dat     <= dly[4];
                    rx_sop     <= close && (len == L5);
                    rx_eop     <= 1'b1;
                    sta_len    <= len;
                    sta_fcser  <= fcs_bad;
                    sta_runt   <= is_runt;
                    sta_long   <= is_long;
                    sta_gmiier <= gmiier;
                    sta_abort  <= cut;
                end else begin
                    rx_drop <= 1'b1;
                end
            end
        end
    end

`ifdef IPSMACGE_RXPAUSE_EN
    localparam logic [LEN_DW-1:0] L16 = LEN_DW'(16);
    localparam logic [LEN_DW-1:0] L17 = LEN_DW'(17);

    // {care, value} for header bytes 1..16; the SA bytes are don't-care
    function automatic logic [8:0] pau_ref(input logic [3:0] idx);
        case (idx)
            4'd0:    return 9'h101;
            4'd1:    return 9'h180;
            4'd2:    return 9'h1C2;
            4'd3:    return 9'h100;
            4'd4:    return 9'h100;
            4'd5:    return 9'h101;
            4'd12:   return 9'h188;
            4'd13:   return 9'h108;
            4'd14:   return 9'h100;
            4'd15:   return 9'h101;
            default: return 9'h000;
        endcase
    endfunction

    logic        pau_match;
    logic [15:0] pau_q;
    logic [8:0]  ref_b;

    assign ref_b = pau_ref(len[3:0]);

    always_ff @(posedge rxclk or negedge rxrst_) begin
        if (!rxrst_) begin
            pau_match  <= 1'b0;
            pau_q      <= '0;
            pau_vld    <= 1'b0;
            pau_quanta <= '0;
        end else begin
            pau_vld    <= 1'b0;
            pau_quanta <= '0;
            if (sof) pau_match <= 1'b1;
            if (byte_in) begin
                if (len < L16 && ref_b[8] && gmii_rxd != ref_b[7:0]) pau_match <= 1'b0;
                if (len == L16) pau_q[15:8] <= gmii_rxd;
                if (len == L17) pau_q[7:0]  <= gmii_rxd;
            end
            if (close && len_ge5 && pau_match && !fcs_bad && !gmiier && !is_runt) begin
                pau_vld    <= 1'b1;
                pau_quanta <= pau_q;
            end
        end
    end
`else
    assign pau_vld    = 1'b0;
    assign pau_quanta = '0;
`endif

endmodule
